// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic_lights design: lamp encodings, the
// road_sequencer phase enum and the default phase durations.
package traffic_pkg;

  localparam logic [2:0] LED_RED    = 3'b100;
  localparam logic [2:0] LED_YELLOW = 3'b010;
  localparam logic [2:0] LED_GREEN  = 3'b001;

  localparam int unsigned DEF_HWY_MIN_GREEN = 16;
  localparam int unsigned DEF_CR_GREEN      = 10;
  localparam int unsigned DEF_YELLOW        = 4;
  localparam int unsigned DEF_ALL_RED       = 2;
  localparam int unsigned DEF_CNT_W         = 8;

  typedef enum logic [2:0] {
    HWY_GREEN  = 3'd0,
    HWY_YELLOW = 3'd1,
    ALL_RED_A  = 3'd2,
    CR_GREEN   = 3'd3,
    CR_YELLOW  = 3'd4,
    ALL_RED_B  = 3'd5
  } phase_t;

  // A duration must fit the phase counter and be at least one cycle.
  function automatic logic dur_ok(input int unsigned d, input int unsigned w);
    return (d >= 1) && (d <= ((32'd1 << w) - 32'd1));
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: synchronous clear, counts up and parks at limit-1,
// flagging done while parked there.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  assign w_last  = i_limit - CNT_W'(1);
  assign o_done  = (r_count == w_last);
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (!o_done) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/road_sequencer.sv
// Master phase controller: owns highway lamps, hands the intersection to
// the country road via enable_countryroad/timeout on a sensor request.
module road_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned HWY_MIN_GREEN = DEF_HWY_MIN_GREEN,
  parameter int unsigned CR_GREEN_LEN  = DEF_CR_GREEN,
  parameter int unsigned YELLOW        = DEF_YELLOW,
  parameter int unsigned ALL_RED       = DEF_ALL_RED,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_sensor,
  output logic       enable_countryroad,
  output logic       timeout,
  output logic [2:0] highway_led,
  output logic       cr_request
);

  generate
    if (!(dur_ok(HWY_MIN_GREEN, CNT_W) && dur_ok(CR_GREEN_LEN, CNT_W) &&
          dur_ok(YELLOW, CNT_W) && dur_ok(ALL_RED, CNT_W))) begin : g_bad_duration
      $error("road_sequencer: every duration must be in 1..2**CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] L_HWY    = CNT_W'(HWY_MIN_GREEN);
  localparam logic [CNT_W-1:0] L_CR     = CNT_W'(CR_GREEN_LEN);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(YELLOW);
  localparam logic [CNT_W-1:0] L_RED    = CNT_W'(ALL_RED);

  phase_t           r_state;
  phase_t           w_state_next;
  logic [CNT_W-1:0] w_limit;
  logic [CNT_W-1:0] w_count;
  logic             w_done;
  logic             w_change;
  logic             w_enter_cr;

  logic             r_cr_request;
  logic [2:0]       r_led;
  logic             r_enable;
  logic             r_timeout;
  logic [2:0]       w_led_next;
  logic             w_enable_next;
  logic             w_timeout_next;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_change),
    .i_limit (w_limit),
    .o_count (w_count),
    .o_done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= HWY_GREEN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_limit      = L_HWY;
    case (r_state)
      HWY_GREEN: begin
        w_limit = L_HWY;
        if (w_done && (r_cr_request || car_sensor)) w_state_next = HWY_YELLOW;
      end
      HWY_YELLOW: begin
        w_limit = L_YELLOW;
        if (w_done) w_state_next = ALL_RED_A;
      end
      ALL_RED_A: begin
        w_limit = L_RED;
        if (w_done) w_state_next = CR_GREEN;
      end
      CR_GREEN: begin
        w_limit = L_CR;
        if (w_done) w_state_next = CR_YELLOW;
      end
      CR_YELLOW: begin
        w_limit = L_YELLOW;
        if (w_done) w_state_next = ALL_RED_B;
      end
      ALL_RED_B: begin
        w_limit = L_RED;
        if (w_done) w_state_next = HWY_GREEN;
      end
      default: begin
        w_limit      = L_HWY;
        w_state_next = HWY_GREEN;
      end
    endcase
  end

  assign w_change   = (w_state_next != r_state);
  assign w_enter_cr = (w_state_next == CR_GREEN) && (r_state != CR_GREEN);

  // Clear on CR_GREEN entry beats a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst || w_enter_cr)                     r_cr_request <= 1'b0;
    else if (car_sensor && r_state != CR_GREEN) r_cr_request <= 1'b1;
  end

  // Lamp/handshake decode of the current phase, registered one cycle later.
  always_comb begin
    w_led_next     = LED_RED;
    w_enable_next  = 1'b0;
    w_timeout_next = 1'b0;
    case (r_state)
      HWY_GREEN:  w_led_next = LED_GREEN;
      HWY_YELLOW: w_led_next = LED_YELLOW;
      CR_GREEN:   w_enable_next = 1'b1;
      CR_YELLOW: begin
        w_enable_next  = 1'b1;
        w_timeout_next = (w_count == '0);
      end
      default: w_led_next = LED_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led     <= LED_GREEN;
      r_enable  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_led     <= w_led_next;
      r_enable  <= w_enable_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign highway_led        = r_led;
  assign enable_countryroad = r_enable;
  assign timeout            = r_timeout;
  assign cr_request         = r_cr_request;

endmodule

// File: tb/tb_road_sequencer.sv
// Bench for road_sequencer: directed plan scenarios plus random sensor
// traffic, all compared cycle by cycle against a handover timeline model.
module tb_road_sequencer;

  localparam int HMG = 16;
  localparam int CRG = 10;
  localparam int Y   = 4;
  localparam int A   = 2;
  localparam int HO_LEN = 2*Y + 2*A + CRG;

  logic       clk;
  logic       rst;
  logic       car_sensor;
  logic       enable_countryroad;
  logic       timeout;
  logic [2:0] highway_led;
  logic       cr_request;

  int n_vec;
  int n_bad;
  int cyc;

  // model: highway green with m_g cycles elapsed, or m_k cycles into a handover
  bit       m_green;
  int       m_g;
  int       m_k;
  bit       m_req;
  logic [2:0] e_led;
  logic     e_en;
  logic     e_to;
  logic     e_req;

  road_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .car_sensor         (car_sensor),
    .enable_countryroad (enable_countryroad),
    .timeout            (timeout),
    .highway_led        (highway_led),
    .cr_request         (cr_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic sens, input logic r);
    bit old_req, in_crg, enter;
    if (r) begin
      m_green = 1; m_g = 0; m_k = 0; m_req = 0;
      e_led = 3'b001; e_en = 0; e_to = 0;
    end else begin
      if (m_green) begin
        e_led = 3'b001; e_en = 0; e_to = 0;
      end else begin
        e_led = (m_k < Y) ? 3'b010 : 3'b100;
        e_en  = (m_k >= Y + A) && (m_k < 2*Y + A + CRG);
        e_to  = (m_k == Y + A + CRG);
      end
      in_crg  = !m_green && (m_k >= Y + A) && (m_k < Y + A + CRG);
      enter   = !m_green && (m_k == Y + A - 1);
      old_req = m_req;
      if (enter) m_req = 0;
      else if (sens && !in_crg) m_req = 1;
      if (m_green) begin
        if (m_g >= HMG - 1 && (old_req || sens)) begin
          m_green = 0; m_k = 0;
        end else begin
          m_g++;
        end
      end else if (m_k == HO_LEN - 1) begin
        m_green = 1; m_g = 0;
      end else begin
        m_k++;
      end
    end
    e_req = m_req;
  endtask

  task automatic tick(input logic sens, input logic r);
    car_sensor = sens;
    rst        = r;
    model_step(sens, r);
    @(posedge clk);
    #1;
    cyc = r ? -1 : cyc + 1;
    check("led",     8'(highway_led),        8'(e_led));
    check("enable",  8'(enable_countryroad), 8'(e_en));
    check("timeout", 8'(timeout),            8'(e_to));
    check("cr_req",  8'(cr_request),         8'(e_req));
    check("inv_en_red",  8'(enable_countryroad && highway_led != 3'b100), 8'd0);
    check("inv_to_en",   8'(timeout && !enable_countryroad), 8'd0);
    check("inv_onehot",  8'($onehot(highway_led)), 8'd1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc = -1;
    rst = 1'b1; car_sensor = 1'b0;

    // idle road: highway stays green
    do_reset(2);
    check("rst_led", 8'(highway_led), 8'h01);
    check("rst_en",  8'(enable_countryroad), 8'h00);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
    check("idle_led", 8'(highway_led), 8'h01);

    // sensor held from cycle 0: full handover and a second one after 16 green cycles
    do_reset(1);
    for (int i = 0; i < 60; i++) begin
      tick(1'b1, 1'b0);
      if (cyc == 15) check("p2_led15", 8'(highway_led), 8'h01);
      if (cyc == 16) check("p2_led16", 8'(highway_led), 8'h02);
      if (cyc == 20) check("p2_led20", 8'(highway_led), 8'h04);
      if (cyc == 21) check("p2_en21",  8'(enable_countryroad), 8'h00);
      if (cyc == 22) check("p2_en22",  8'(enable_countryroad), 8'h01);
      if (cyc == 31) check("p2_to31",  8'(timeout), 8'h00);
      if (cyc == 32) check("p2_to32",  8'(timeout), 8'h01);
      if (cyc == 33) check("p2_to33",  8'(timeout), 8'h00);
      if (cyc == 36) check("p2_en36",  8'(enable_countryroad), 8'h00);
      if (cyc == 38) check("p2_led38", 8'(highway_led), 8'h01);
      if (cyc == 40) check("p4_req40", 8'(cr_request), 8'h01);
      if (cyc == 53) check("p4_led53", 8'(highway_led), 8'h01);
      if (cyc == 54) check("p4_led54", 8'(highway_led), 8'h02);
    end

    // single sensor pulse at cycle 40
    do_reset(1);
    for (int i = 0; i < 60; i++) begin
      tick(i == 40, 1'b0);
      if (cyc == 40) check("p3_req40", 8'(cr_request), 8'h01);
      if (cyc == 41) check("p3_led41", 8'(highway_led), 8'h02);
      if (cyc == 46) check("p3_en46",  8'(enable_countryroad), 8'h00);
      if (cyc == 47) check("p3_en47",  8'(enable_countryroad), 8'h01);
    end

    // reset in the middle of CR_GREEN
    do_reset(1);
    for (int i = 0; i < 27; i++) tick(1'b1, 1'b0);
    check("p5_en_pre", 8'(enable_countryroad), 8'h01);
    tick(1'b0, 1'b1);
    check("p5_en",  8'(enable_countryroad), 8'h00);
    check("p5_led", 8'(highway_led), 8'h01);
    check("p5_req", 8'(cr_request), 8'h00);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0);
      check("p5_no_to", 8'(timeout), 8'h00);
    end

    // random traffic with varying density and occasional resets
    for (int blk = 0; blk < 10; blk++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++)
        tick($urandom_range(0, 99) < dens, $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
